// File: rtl/riscv_pkg.sv
// riscv_pkg: shared operand-select encodings, scoreboard entry type and opcode constants
package riscv_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2, OP1_RSV = 2'd3} op1_sel_e;
  typedef enum logic {OP2_RS2 = 1'b0, OP2_IMM = 1'b1} op2_sel_e;
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: resolves one source register against the scoreboard, youngest match wins
module fwd_match
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                    en,
  input  logic [4:0]              idx,
  input  sb_entry_t [DEPTH-1:0]   sb,
  input  logic [DEPTH*XLEN-1:0]   stage_data,
  input  logic [XLEN-1:0]         rf_data,
  output logic                    hit,
  output logic                    ready,
  output logic [XLEN-1:0]         data
);
  always_comb begin
    hit   = 1'b0;
    ready = 1'b1;
    data  = (idx == 5'd0) ? '0 : rf_data;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (en && idx != 5'd0 && sb[k].vld && sb[k].rd == idx) begin
        hit   = 1'b1;
        ready = !(sb[k].is_load && k < LOAD_LAT);
        data  = stage_data[k*XLEN +: XLEN];
      end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use stall generation for the decode stage
module fwd_hazard_unit
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_en,
  input  logic                  id_rs2_en,
  input  logic [4:0]            id_rd,
  input  logic                  id_rd_en,
  input  logic                  id_is_load,
  input  logic [1:0]            id_op1_sel,
  input  logic                  id_op2_sel,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic                  flush,
  output logic                  stall,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  output logic [XLEN-1:0]       rs2_val,
  output logic [31:0]           stall_cnt
);
  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  sb_entry_t ent;
  logic [31:0] cnt_q, cnt_d;
  logic hit1, rdy1, hit2, rdy2, issue;
  logic [XLEN-1:0] fwd1, fwd2;
  fwd_match #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) u_rs1 (
    .en(id_rs1_en), .idx(id_rs1), .sb(sb_q), .stage_data(stage_data), .rf_data(rf_data1),
    .hit(hit1), .ready(rdy1), .data(fwd1)
  );
  fwd_match #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) u_rs2 (
    .en(id_rs2_en), .idx(id_rs2), .sb(sb_q), .stage_data(stage_data), .rf_data(rf_data2),
    .hit(hit2), .ready(rdy2), .data(fwd2)
  );
  always_comb begin
    stall       = id_valid & ~flush & ((hit1 & ~rdy1) | (hit2 & ~rdy2));
    issue       = id_valid & ~flush & ~stall;
    ent.vld     = issue & id_rd_en & (id_rd != 5'd0);
    ent.rd      = issue ? id_rd : 5'd0;
    ent.is_load = issue & id_is_load;
    sb_d        = {sb_q[DEPTH-2:0], ent};
    cnt_d       = (stall && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
    op1         = op1_sel_e'(id_op1_sel) == OP1_RS1 ? fwd1 :
                  op1_sel_e'(id_op1_sel) == OP1_PC  ? id_pc : '0;
    op2         = op2_sel_e'(id_op2_sel) == OP2_IMM ? id_imm : fwd2;
    rs2_val     = fwd2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and randomized checks against an instruction-history model
module tb_fwd_hazard_unit;
  localparam int XLEN = 32, DEPTH = 3, LOAD_LAT = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_is_load, id_op2_sel, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_op1_sel;
  logic [XLEN-1:0] id_pc, id_imm, rf_data1, rf_data2, op1, op2, rs2_val;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic stall;
  logic [31:0] stall_cnt;
  int checks = 0, errors = 0;
  typedef struct {bit vld; bit [4:0] rd; bit ld;} ins_t;
  ins_t hist[$];
  longint exp_cnt;

  fwd_hazard_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_en(id_rd_en),
    .id_is_load(id_is_load), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
    .id_pc(id_pc), .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .stage_data(stage_data), .flush(flush), .stall(stall), .op1(op1), .op2(op2),
    .rs2_val(rs2_val), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void resolve(input bit en, input bit [4:0] idx, input logic [31:0] rf,
                                  output bit not_ready, output logic [31:0] v);
    not_ready = 0;
    v = (idx == 0) ? 32'd0 : rf;
    if (!en || idx == 0) return;
    for (int age = 0; age < hist.size(); age++)
      if (hist[age].vld && hist[age].rd == idx) begin
        not_ready = hist[age].ld && age < LOAD_LAT;
        v = stage_data[age*XLEN +: XLEN];
        return;
      end
  endfunction

  function automatic bit exp_stall();
    bit n1, n2;
    logic [31:0] v1, v2;
    resolve(id_rs1_en, id_rs1, rf_data1, n1, v1);
    resolve(id_rs2_en, id_rs2, rf_data2, n2, v2);
    return id_valid && !flush && (n1 || n2);
  endfunction

  task automatic check_all(input string tag);
    bit n1, n2, es;
    logic [31:0] v1, v2, e1;
    #3;
    resolve(id_rs1_en, id_rs1, rf_data1, n1, v1);
    resolve(id_rs2_en, id_rs2, rf_data2, n2, v2);
    es = exp_stall();
    e1 = id_op1_sel == 2'd0 ? v1 : id_op1_sel == 2'd1 ? id_pc : 32'd0;
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, es});
    chk({tag, ".cnt"}, stall_cnt, exp_cnt[31:0]);
    if (!es) begin
      chk({tag, ".op1"}, op1, e1);
      chk({tag, ".op2"}, op2, id_op2_sel ? id_imm : v2);
      chk({tag, ".rs2_val"}, rs2_val, v2);
    end
  endtask

  task automatic tick();
    bit es;
    ins_t n;
    es = exp_stall();
    n.vld = id_valid && !es && !flush && id_rd_en && id_rd != 0;
    n.rd = id_rd;
    n.ld = id_is_load;
    @(posedge clk);
    if (es && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
    hist.push_front(n);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic clear_model();
    ins_t z;
    z = '{0, 0, 0};
    hist = '{z, z, z};
    exp_cnt = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
    id_rd = 0; id_rd_en = 0; id_is_load = 0; id_op1_sel = 0; id_op2_sel = 0; flush = 0;
  endtask

  task automatic issue(input bit [4:0] rd, input bit rd_en, input bit ld, input bit [4:0] rs1,
                       input bit rs1_en, input bit [4:0] rs2, input bit rs2_en,
                       input bit [1:0] s1, input bit s2);
    id_valid = 1; id_rd = rd; id_rd_en = rd_en; id_is_load = ld;
    id_rs1 = rs1; id_rs1_en = rs1_en; id_rs2 = rs2; id_rs2_en = rs2_en;
    id_op1_sel = s1; id_op2_sel = s2; flush = 0;
  endtask

  initial begin
    idle();
    id_pc = 32'h1000; id_imm = 32'h24; rf_data1 = 32'hA1; rf_data2 = 32'hB2;
    stage_data = {32'h33, 32'h22, 32'h11};
    clear_model();
    #2;
    check_all("reset");
    chk("reset.stall_const", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    // load-use: one stall cycle then forward from stage 1
    issue(8, 1, 1, 0, 0, 0, 0, 0, 0);
    check_all("lw");
    tick();
    issue(9, 1, 0, 8, 1, 1, 1, 0, 0);
    stage_data = {32'h33, 32'h77, 32'h66};
    check_all("lu.stall");
    chk("lu.stall_const", {31'd0, stall}, 32'd1);
    tick();
    check_all("lu.release");
    chk("lu.op1_const", op1, 32'h77);
    chk("lu.cnt_const", stall_cnt, 32'd1);
    tick();
    // EX forwarding to both operands
    issue(5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    issue(6, 1, 0, 5, 1, 5, 1, 0, 0);
    stage_data = {32'h33, 32'h22, 32'h11};
    check_all("ex_fwd");
    chk("ex_fwd.op1_const", op1, 32'h11);
    chk("ex_fwd.op2_const", op2, 32'h11);
    tick();
    // youngest of two writers wins
    issue(7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    issue(7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    issue(1, 1, 0, 7, 1, 0, 0, 0, 0);
    stage_data = {32'hBB, 32'h00, 32'hAA};
    check_all("youngest");
    chk("youngest.op1_const", op1, 32'hAA);
    tick();
    // flush beats a load-use stall and the killed instruction never forwards
    issue(8, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    issue(9, 1, 0, 8, 1, 0, 0, 0, 0);
    flush = 1;
    check_all("flush");
    chk("flush.stall_const", {31'd0, stall}, 32'd0);
    tick();
    issue(10, 1, 0, 9, 1, 0, 0, 0, 0);
    rf_data1 = 32'h1234;
    stage_data = {32'h33, 32'h22, 32'hDEAD};
    check_all("flush.bubble");
    chk("flush.bubble_const", op1, 32'h1234);
    tick();
    // x0 writer never forwards
    issue(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    issue(1, 1, 0, 0, 1, 0, 0, 0, 0);
    stage_data = {32'h33, 32'h22, 32'h55};
    check_all("x0");
    chk("x0.op1_const", op1, 32'd0);
    tick();
    // store: operands from different stages, op2 from imm
    issue(2, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    issue(3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    issue(0, 0, 0, 2, 1, 3, 1, 0, 1);
    id_imm = 32'h4;
    stage_data = {32'h33, 32'h100, 32'h7};
    check_all("sw");
    chk("sw.op1_const", op1, 32'h100);
    chk("sw.op2_const", op2, 32'h4);
    chk("sw.rs2_const", rs2_val, 32'h7);
    tick();
    // reset during a stall drops it immediately
    issue(11, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    issue(12, 1, 0, 11, 1, 0, 0, 0, 0);
    #2;
    chk("midrst.pre", {31'd0, stall}, 32'd1);
    rst_n = 0;
    clear_model();
    #1;
    chk("midrst.stall", {31'd0, stall}, 32'd0);
    chk("midrst.cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rs1_en = ($urandom_range(0, 4) != 0); id_rs2_en = ($urandom_range(0, 4) != 0);
      id_rd = 5'($urandom_range(0, 7)); id_rd_en = ($urandom_range(0, 3) != 0);
      id_is_load = ($urandom_range(0, 2) == 0);
      id_op1_sel = 2'($urandom_range(0, 3)); id_op2_sel = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 7) == 0);
      id_pc = $urandom; id_imm = $urandom; rf_data1 = $urandom; rf_data2 = $urandom;
      stage_data = {$urandom, $urandom, $urandom};
      check_all("rand");
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/data width.
REQ-002 The block SHALL have parameter DEPTH, default 3, tracked in-flight stages; stage 0 is EX (youngest), stage DEPTH-1 is the oldest.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, the first stage index at which load data is valid; legal range 1..DEPTH-1.
REQ-004 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode slot holds an instruction.
- id_rs1, id_rs2  in  5  source register indices.
- id_rs1_en, id_rs2_en  in  1  source register is read.
- id_rd  in  5  destination register index.
- id_rd_en  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- id_op1_sel  in  2  0 = rs1, 1 = pc, 2 = zero, 3 = reserved (drives zero).
- id_op2_sel  in  1  0 = rs2, 1 = imm.
- id_pc, id_imm  in  XLEN  decode pc and immediate.
- rf_data1, rf_data2  in  XLEN  register file read data.
- stage_data  in  DEPTH*XLEN  result per stage; slice k = stage k.
- flush  in  1  kill decode instruction (taken branch/jump).
- stall  out  1  hold PC and decode; insert bubble.
- op1, op2  out  XLEN  ALU operands.
- rs2_val  out  XLEN  forwarded rs2 for store data and branch compare, independent of id_op2_sel.
- stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-005 The block SHALL keep a DEPTH-entry scoreboard; each entry holds {vld, rd, is_load}.
REQ-006 On each clock edge, entry k SHALL take entry k-1 for k ≥ 1, and the oldest entry SHALL be discarded.
REQ-007 When stall=0, flush=0 and id_valid=1, entry 0 SHALL load {id_rd_en & (id_rd≠0), id_rd, id_is_load}.
REQ-008 Otherwise (stall, flush or id_valid=0), entry 0 SHALL load a bubble (vld=0).
REQ-009 A source SHALL match entry k only if: its _en=1, index ≠ 0, entry vld=1, and rd equals the index.
REQ-010 The youngest (lowest k) matching entry SHALL win.
REQ-011 A winning entry with is_load=1 and k < LOAD_LAT SHALL be "not ready"; any other winning entry SHALL forward stage_data slice k.
REQ-012 A source with no match SHALL use rf_data1 or rf_data2; a source with index 0 SHALL read 0.
REQ-013 stall SHALL equal id_valid & ~flush & (rs1 not ready | rs2 not ready); it is combinational, zero-cycle.
REQ-014 Because a stall inserts bubbles, stall SHALL persist exactly LOAD_LAT-k cycles and then release automatically.
REQ-015 op1 SHALL be the forwarded rs1, id_pc or 0 per id_op1_sel.
REQ-016 op2 SHALL be the forwarded rs2 or id_imm per id_op2_sel.
REQ-017 rs2_val SHALL always be the forwarded rs2.
REQ-018 Both operands SHALL forward independently and simultaneously, from the same or different stages.
REQ-019 While stall=1, op1/op2 values are don't-care.
REQ-020 stall_cnt SHALL increment on every edge with stall=1 and saturate at 0xFFFFFFFF.
REQ-021 flush and stall in the same cycle: flush SHALL win, stall=0, and a bubble SHALL be inserted.

Reset
REQ-022 While rst_n=0, all entry vld bits and stall_cnt SHALL be 0; rd and is_load SHALL be 0.
REQ-023 After reset, stall SHALL be 0, and op1/op2 SHALL follow rf_data, pc and imm.
REQ-024 Reset asserted mid-stall SHALL drop stall in the same cycle via the vld clear.

Structure
REQ-025 Shared package riscv_pkg SHALL hold: op1-select and op2-select enums, XLEN default, and opcode constants.
REQ-026 One sub-module, fwd_match, SHALL resolve a single source against the scoreboard, returning {hit, ready, data}; it SHALL be instantiated twice.
REQ-027 The scoreboard SHALL be the only sequential state besides stall_cnt.

Verification
REQ-028 add x5 in EX (stage_data[0]=0x11), next instruction add x6,x5,x5 -> op1=op2=0x11, stall=0.
REQ-029 x7 in stage 0 (0xAA) and stage 2 (0xBB), rs1=x7 -> op1=0xAA (youngest wins).
REQ-030 lw x8 then add x9,x8,x1 (LOAD_LAT=1) -> stall=1 for one cycle, then op1 = stage_data[1], stall_cnt=1.
REQ-031 Same as REQ-030 with flush=1 in the stall cycle -> stall=0, next entry 0 vld=0.
REQ-032 Writer to x0 (stage_data[0]=0x55), rs1=x0 -> op1=0; no stall.
REQ-033 sw with rs1=x2 forwarded from stage 1 (0x100), rs2=x3 from stage 0 (0x7), op2_sel=imm=0x4 -> op1=0x100, op2=0x4, rs2_val=0x7.
